// File: rtl/lab2_proc_test_mem_responder_if.sv
`default_nettype none
// ============================================================================
// lab2_proc_test_mem_responder_if
// Memory request/response message types and the val/rdy stream interface
// Revision: 1.0
// ============================================================================

package lab2_proc_test_mem_responder_pkg;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [31:0] addr;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_req_4B_t;

   typedef struct packed {
      logic [2:0]  msg_type;
      logic [7:0]  opaque;
      logic [1:0]  test;
      logic [1:0]  len;
      logic [31:0] data;
   } mem_resp_4B_t;

endpackage

interface lab2_proc_test_mem_responder_if;
   import lab2_proc_test_mem_responder_pkg::*;

   logic         reqstream_val;
   logic         reqstream_rdy;
   mem_req_4B_t  reqstream_msg;
   logic         respstream_val;
   logic         respstream_rdy;
   mem_resp_4B_t respstream_msg;

   modport master (
      output reqstream_val, reqstream_msg, respstream_rdy,
      input  reqstream_rdy, respstream_val, respstream_msg
   );

   modport slave (
      input  reqstream_val, reqstream_msg, respstream_rdy,
      output reqstream_rdy, respstream_val, respstream_msg
   );

endinterface

`default_nettype wire

// File: rtl/lab2_proc_test_mem_responder.sv
`default_nettype none
// ============================================================================
// lab2_proc_test_mem_responder
// Word memory answering val/rdy requests in order after a fixed extra latency
// Revision: 1.0
// ============================================================================

module lab2_proc_test_mem_responder
   import lab2_proc_test_mem_responder_pkg::*;
#(
   parameter int unsigned p_mem_nbytes = 4096,
   parameter int unsigned p_latency    = 0
)(
   input  wire                               clk,
   input  wire                               reset,
   lab2_proc_test_mem_responder_if.slave     mem,
   output logic                              err
);

   localparam int unsigned c_aw     = $clog2(p_mem_nbytes);
   localparam int unsigned c_nwords = p_mem_nbytes / 4;
   localparam int unsigned c_depth  = p_latency + 2;
   localparam int unsigned c_pw     = $clog2(c_depth);
   localparam int unsigned c_cw     = $clog2(c_depth + 1);

   localparam logic [c_cw-1:0] c_depth_w    = c_cw'(c_depth);
   localparam logic [c_pw-1:0] c_last_ptr   = c_pw'(c_depth - 1);
   localparam logic [31:0]     c_nbytes_w   = 32'(p_mem_nbytes);
   localparam logic [2:0]      c_type_read  = 3'd0;
   localparam logic [2:0]      c_type_write = 3'd1;
   localparam logic [2:0]      c_type_init  = 3'd2;

   logic [31:0]       r_mem [c_nwords];
   mem_resp_4B_t      r_q   [c_depth];
   logic [c_pw-1:0]   r_head;
   logic [c_pw-1:0]   r_tail;
   logic [c_cw-1:0]   r_count;
   logic [c_cw-1:0]   r_outstanding;
   logic              r_err;

   mem_req_4B_t       w_req;
   logic [c_aw-3:0]   w_idx;
   logic              w_in_range;
   logic              w_is_read;
   logic              w_is_write;
   logic              w_bad;
   logic              w_rdy;
   logic              w_go;
   logic              w_deq;
   mem_resp_4B_t      w_resp;
   logic              w_dl_val;
   mem_resp_4B_t      w_dl_msg;

   function automatic logic [c_pw-1:0] f_next(input logic [c_pw-1:0] p);
      return (p == c_last_ptr) ? '0 : p + c_pw'(1);
   endfunction

   assign w_req      = mem.reqstream_msg;
   assign w_idx      = w_req.addr[c_aw-1:2];
   assign w_in_range = (w_req.addr < c_nbytes_w);
   assign w_is_read  = (w_req.msg_type == c_type_read);
   assign w_is_write = (w_req.msg_type == c_type_write) || (w_req.msg_type == c_type_init);
   assign w_bad      = !w_in_range || !(w_is_read || w_is_write);

   // Outstanding covers both the delay line and the queue, so this bound
   // alone guarantees the queue can never overflow.
   assign w_rdy = !reset && (r_outstanding < c_depth_w);
   assign w_go  = mem.reqstream_val && w_rdy;
   assign w_deq = (r_count != '0) && mem.respstream_rdy;

   always_comb begin
      w_resp          = '0;
      w_resp.msg_type = w_req.msg_type;
      w_resp.opaque   = w_req.opaque;
      w_resp.len      = w_req.len;
      w_resp.test     = 2'b00;
      w_resp.data     = (w_is_read && w_in_range) ? r_mem[w_idx] : 32'd0;
   end

   // Array contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (w_go && w_is_write && w_in_range) begin
         r_mem[w_idx] <= w_req.data;
      end
   end

   generate
      if (p_latency == 0) begin : g_no_delay
         assign w_dl_val = w_go;
         assign w_dl_msg = w_resp;
      end else begin : g_delay
         logic [p_latency-1:0] r_val;
         mem_resp_4B_t         r_msg [p_latency];

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_val <= '0;
            end else begin
               r_val[0] <= w_go;
               for (int i = 1; i < int'(p_latency); i++) begin
                  r_val[i] <= r_val[i-1];
               end
            end
         end

         always_ff @(posedge clk) begin
            r_msg[0] <= w_resp;
            for (int i = 1; i < int'(p_latency); i++) begin
               r_msg[i] <= r_msg[i-1];
            end
         end

         assign w_dl_val = r_val[p_latency-1];
         assign w_dl_msg = r_msg[p_latency-1];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (w_dl_val) begin
         r_q[r_tail] <= w_dl_msg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head        <= '0;
         r_tail        <= '0;
         r_count       <= '0;
         r_outstanding <= '0;
         r_err         <= 1'b0;
      end else begin
         if (w_dl_val) begin
            r_tail <= f_next(r_tail);
         end
         if (w_deq) begin
            r_head <= f_next(r_head);
         end
         case ({w_dl_val, w_deq})
            2'b10:   r_count <= r_count + c_cw'(1);
            2'b01:   r_count <= r_count - c_cw'(1);
            default: r_count <= r_count;
         endcase
         case ({w_go, w_deq})
            2'b10:   r_outstanding <= r_outstanding + c_cw'(1);
            2'b01:   r_outstanding <= r_outstanding - c_cw'(1);
            default: r_outstanding <= r_outstanding;
         endcase
         if (w_go && w_bad) begin
            r_err <= 1'b1;
         end
      end
   end

   assign mem.reqstream_rdy  = w_rdy;
   assign mem.respstream_val = (r_count != '0);
   assign mem.respstream_msg = r_q[r_head];
   assign err                = r_err;

endmodule

`default_nettype wire
